// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - RV32 data-memory responder with configurable wait states
// Accepts one load/store at a time, commits it on RESP entry, returns a one-cycle response.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         AW  = $clog2(DEPTH);
  localparam logic [2:0] LAT = 3'(LATENCY);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_next;
  logic        w_enter_resp;

  logic        r_we;
  logic [2:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;
  logic        r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // req_ready is gated by rst so nothing is offered while reset is held
  always_comb begin
    w_next       = r_state;
    w_cnt_next   = r_cnt;
    req_ready    = 1'b0;
    w_enter_resp = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = rst;
        if (req_valid && rst) begin
          w_cnt_next = LAT;
          if (LAT == 3'd0) begin
            w_next       = RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_next = BUSY;
          end
        end
      end
      BUSY: begin
        w_cnt_next = r_cnt - 3'd1;
        if (r_cnt <= 3'd1) begin
          w_next       = RESP;
          w_enter_resp = 1'b1;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_size  <= 3'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else if (req_ready && req_valid) begin
      r_we    <= req_we;
      r_size  <= req_size;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  // With zero latency the access is committed on the accept edge, before the latch is loaded
  logic        w_we;
  logic [2:0]  w_size;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [AW-1:0] w_idx;
  logic [31:0] w_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [4:0]  w_shift;
  logic [31:0] w_mask;
  logic [31:0] w_new;
  logic [31:0] w_load;
  logic        w_err;

  assign w_we    = (r_state == IDLE) ? req_we    : r_we;
  assign w_size  = (r_state == IDLE) ? req_size  : r_size;
  assign w_addr  = (r_state == IDLE) ? req_addr  : r_addr;
  assign w_wdata = (r_state == IDLE) ? req_wdata : r_wdata;

  assign w_idx   = w_addr[AW+1:2];
  assign w_word  = r_mem[w_idx];
  assign w_shift = {w_addr[1:0], 3'b000};
  assign w_byte  = w_word[w_shift +: 8];
  assign w_half  = w_word[{w_addr[1], 4'b0000} +: 16];

  always_comb begin
    w_err  = 1'b0;
    w_mask = 32'hFFFF_FFFF;
    w_load = w_word;
    case (w_size)
      3'b000: begin
        w_mask = 32'h0000_00FF << w_shift;
        w_load = {{24{w_byte[7]}}, w_byte};
      end
      3'b100: begin
        w_mask = 32'h0000_00FF << w_shift;
        w_load = {24'd0, w_byte};
      end
      3'b001: begin
        w_err  = w_addr[0];
        w_mask = 32'h0000_FFFF << w_shift;
        w_load = {{16{w_half[15]}}, w_half};
      end
      3'b101: begin
        w_err  = w_addr[0];
        w_mask = 32'h0000_FFFF << w_shift;
        w_load = {16'd0, w_half};
      end
      3'b010:  w_err = (w_addr[1:0] != 2'b00);
      default: w_err = 1'b1;
    endcase
    if (w_we && w_size[2]) w_err = 1'b1;
    if (|w_addr[31:AW+2]) w_err = 1'b1;
  end

  assign w_new = (w_word & ~w_mask) | ((w_wdata << w_shift) & w_mask);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'd0;
    end else if (w_enter_resp && w_we && !w_err) begin
      r_mem[w_idx] <= w_new;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_enter_resp) begin
      r_rdata <= (w_err || w_we) ? 32'd0 : w_load;
      r_err   <= w_err;
    end
  end

  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
// Two instances (LATENCY 3 and 0) checked against a byte-addressed reference memory.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_a = 1'b0;
  logic        valid_z = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_size = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        ready_a, ready_z, rv_a, rv_z, err_a, err_z;
  logic [31:0] rd_a, rd_z;

  int passed = 0;
  int total  = 0;
  byte unsigned ref_mem [2][1024];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(256), .LATENCY(3)) u_dut_a (
    .clk(clk), .rst(rst), .req_valid(valid_a), .req_ready(ready_a),
    .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv_a), .resp_rdata(rd_a), .resp_err(err_a));

  dmem_responder #(.DEPTH(256), .LATENCY(0)) u_dut_z (
    .clk(clk), .rst(rst), .req_valid(valid_z), .req_ready(ready_z),
    .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv_z), .resp_rdata(rd_z), .resp_err(err_z));

  // Reference: byte memory, access width from size, error rules applied directly
  function automatic void model(input int sel, input logic we, input logic [2:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic err, output logic [31:0] rd);
    int nb;
    logic [31:0] v;
    err = (size == 3'd3 || size == 3'd6 || size == 3'd7) || (we && size >= 3'd4) ||
          ((size == 3'd1 || size == 3'd5) && addr[0]) ||
          (size == 3'd2 && addr[1:0] != 2'b00) || (addr >= 32'd1024);
    rd = 32'd0;
    v  = 32'd0;
    nb = (size[1:0] == 2'd0) ? 1 : (size[1:0] == 2'd1) ? 2 : 4;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < nb; i++) ref_mem[sel][addr + i] = wdata[8*i +: 8];
      end else begin
        for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[sel][addr + i];
        case (size)
          3'd0:    rd = {{24{v[7]}}, v[7:0]};
          3'd1:    rd = {{16{v[15]}}, v[15:0]};
          default: rd = v;
        endcase
      end
    end
  endfunction

  task automatic clear_ref();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 1024; i++) ref_mem[s][i] = 8'd0;
  endtask

  task automatic do_req(input int sel, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rd, output logic err,
                        output logic rv_after, output logic rdy_after);
    int n;
    req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
    if (sel == 0) valid_a = 1'b1; else valid_z = 1'b1;
    n = 0;
    while (((sel == 0) ? ready_a : ready_z) !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    valid_a = 1'b0; valid_z = 1'b0;
    req_we = 1'($urandom); req_size = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = -1; rd = 32'd0; err = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (((sel == 0) ? rv_a : rv_z) === 1'b1) begin
        lat = i;
        rd  = (sel == 0) ? rd_a : rd_z;
        err = (sel == 0) ? err_a : err_z;
        break;
      end
    end
    @(negedge clk);
    rv_after  = (sel == 0) ? rv_a : rv_z;
    rdy_after = (sel == 0) ? ready_a : ready_z;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (ready_a !== 1'b0 || ready_z !== 1'b0) $display("FAIL reset_ready got %b/%b want 0/0", ready_a, ready_z); else passed++;
    total++; if (rv_a !== 1'b0 || rv_z !== 1'b0) $display("FAIL reset_valid got %b/%b want 0/0", rv_a, rv_z); else passed++;
    total++; if (rd_a !== 32'd0 || err_a !== 1'b0) $display("FAIL reset_resp got %h/%b want 0/0", rd_a, err_a); else passed++;
    rst = 1'b1;
    clear_ref();
    @(negedge clk);
    total++; if (ready_a !== 1'b1 || ready_z !== 1'b1) $display("FAIL release_ready got %b/%b want 1/1", ready_a, ready_z); else passed++;
  endtask

  typedef struct {
    logic we; logic [2:0] size; logic [31:0] addr; logic [31:0] wdata;
    logic [31:0] exp_rd; logic exp_err;
  } dir_t;

  task automatic test_directed();
    dir_t t [18];
    int lat; logic [31:0] rd, mrd; logic err, merr, rva, rdy;
    t[0]  = '{1'b1, 3'd2, 32'h008, 32'h8888_8888, 32'h0, 1'b0};
    t[1]  = '{1'b0, 3'd2, 32'h008, 32'h0, 32'h8888_8888, 1'b0};
    t[2]  = '{1'b0, 3'd2, 32'h00C, 32'h0, 32'h0, 1'b0};
    t[3]  = '{1'b1, 3'd0, 32'h011, 32'h1234_5680, 32'h0, 1'b0};
    t[4]  = '{1'b0, 3'd0, 32'h011, 32'h0, 32'hFFFF_FF80, 1'b0};
    t[5]  = '{1'b0, 3'd4, 32'h011, 32'h0, 32'h0000_0080, 1'b0};
    t[6]  = '{1'b0, 3'd2, 32'h010, 32'h0, 32'h0000_8000, 1'b0};
    t[7]  = '{1'b1, 3'd1, 32'h016, 32'hCAFE_BEEF, 32'h0, 1'b0};
    t[8]  = '{1'b0, 3'd1, 32'h016, 32'h0, 32'hFFFF_BEEF, 1'b0};
    t[9]  = '{1'b0, 3'd5, 32'h016, 32'h0, 32'h0000_BEEF, 1'b0};
    t[10] = '{1'b0, 3'd2, 32'h014, 32'h0, 32'hBEEF_0000, 1'b0};
    t[11] = '{1'b0, 3'd1, 32'h003, 32'h0, 32'h0, 1'b1};
    t[12] = '{1'b1, 3'd2, 32'h400, 32'hDEAD_BEEF, 32'h0, 1'b1};
    t[13] = '{1'b0, 3'd2, 32'h000, 32'h0, 32'h0, 1'b0};
    t[14] = '{1'b1, 3'd4, 32'h020, 32'h0000_00AA, 32'h0, 1'b1};
    t[15] = '{1'b0, 3'd2, 32'h020, 32'h0, 32'h0, 1'b0};
    t[16] = '{1'b0, 3'd2, 32'h002, 32'h0, 32'h0, 1'b1};
    t[17] = '{1'b0, 3'd3, 32'h000, 32'h0, 32'h0, 1'b1};
    for (int i = 0; i < 18; i++) begin
      model(0, t[i].we, t[i].size, t[i].addr, t[i].wdata, merr, mrd);
      do_req(0, t[i].we, t[i].size, t[i].addr, t[i].wdata, lat, rd, err, rva, rdy);
      total++; if (lat !== 4) $display("FAIL dir%0d_latency got %0d want 4", i, lat); else passed++;
      total++; if (rd !== t[i].exp_rd || err !== t[i].exp_err) $display("FAIL dir%0d_resp got %h/%b want %h/%b", i, rd, err, t[i].exp_rd, t[i].exp_err); else passed++;
      total++; if (rd !== mrd || err !== merr) $display("FAIL dir%0d_model got %h/%b want %h/%b", i, rd, err, mrd, merr); else passed++;
      total++; if (rva !== 1'b0 || rdy !== 1'b1) $display("FAIL dir%0d_after got valid %b ready %b want 0/1", i, rva, rdy); else passed++;
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd, mrd, a, wd; logic err, merr, rva, rdy, we; logic [2:0] sz;
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom);
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2)) | ((!we && $urandom_range(0, 1) == 1) ? 3'd4 : 3'd0);
      a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 63));
      wd = $urandom;
      model(0, we, sz, a, wd, merr, mrd);
      do_req(0, we, sz, a, wd, lat, rd, err, rva, rdy);
      total++; if (lat !== 4 || rva !== 1'b0) $display("FAIL rnd%0d_timing got lat %0d valid_after %b want 4/0", i, lat, rva); else passed++;
      total++; if (rd !== mrd || err !== merr) $display("FAIL rnd%0d_resp we=%b size=%0d addr=%h got %h/%b want %h/%b", i, we, sz, a, rd, err, mrd, merr); else passed++;
    end
  endtask

  task automatic test_back_to_back(input int sel, input int latency);
    int win;
    logic [15:0] got_rdy, got_rv, exp_rdy, exp_rv;
    win = 2 * (latency + 2);
    got_rdy = '0; got_rv = '0; exp_rdy = '0; exp_rv = '0;
    for (int i = 0; i < win; i++) begin
      exp_rdy[i] = ((i % (latency + 2)) == 0);
      exp_rv[i]  = ((i % (latency + 2)) == latency + 1);
    end
    req_we = 1'b0; req_size = 3'd2; req_addr = 32'h0; req_wdata = 32'h0;
    if (sel == 0) valid_a = 1'b1; else valid_z = 1'b1;
    for (int i = 0; i < win; i++) begin
      if (i > 0) @(negedge clk);
      got_rdy[i] = (sel == 0) ? ready_a : ready_z;
      got_rv[i]  = (sel == 0) ? rv_a : rv_z;
    end
    valid_a = 1'b0; valid_z = 1'b0;
    @(negedge clk);
    total++; if (got_rdy !== exp_rdy) $display("FAIL b2b_ready_lat%0d got %b want %b", latency, got_rdy, exp_rdy); else passed++;
    total++; if (got_rv !== exp_rv) $display("FAIL b2b_valid_lat%0d got %b want %b", latency, got_rv, exp_rv); else passed++;
  endtask

  task automatic test_zero_latency();
    int lat; logic [31:0] rd, mrd; logic err, merr, rva, rdy;
    model(1, 1'b1, 3'd1, 32'h3FE, 32'h0000_7A5C, merr, mrd);
    do_req(1, 1'b1, 3'd1, 32'h3FE, 32'h0000_7A5C, lat, rd, err, rva, rdy);
    total++; if (lat !== 1 || rva !== 1'b0 || rdy !== 1'b1) $display("FAIL z_store_timing got lat %0d valid %b ready %b want 1/0/1", lat, rva, rdy); else passed++;
    model(1, 1'b0, 3'd2, 32'h3FC, 32'h0, merr, mrd);
    do_req(1, 1'b0, 3'd2, 32'h3FC, 32'h0, lat, rd, err, rva, rdy);
    total++; if (rd !== 32'h7A5C_0000 || err !== 1'b0 || rd !== mrd) $display("FAIL z_load got %h/%b want %h/0", rd, err, mrd); else passed++;
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic err, rva, rdy, any;
    req_we = 1'b1; req_size = 3'd2; req_addr = 32'h020; req_wdata = 32'h1234_5678;
    valid_a = 1'b1;
    @(posedge clk);
    #1 valid_a = 1'b0;
    @(negedge clk);
    total++; if (ready_a !== 1'b0) $display("FAIL mid_busy_ready got %b want 0", ready_a); else passed++;
    rst = 1'b0;
    any = 1'b0;
    repeat (3) begin
      @(negedge clk);
      any = any | rv_a;
    end
    rst = 1'b1;
    clear_ref();
    repeat (6) begin
      @(negedge clk);
      any = any | rv_a;
    end
    total++; if (any !== 1'b0) $display("FAIL mid_no_resp got %b want 0", any); else passed++;
    do_req(0, 1'b0, 3'd2, 32'h020, 32'h0, lat, rd, err, rva, rdy);
    total++; if (rd !== 32'h0 || err !== 1'b0 || lat !== 4) $display("FAIL mid_reload got %h/%b lat %0d want 0/0 lat 4", rd, err, lat); else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back(0, 3);
    test_back_to_back(1, 0);
    test_zero_latency();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
